flit_port_buffer: RTL and testbench
===================================

# flit_port_buffer

Ingress buffer for one router link port (N, E, S or W) that sits directly upstream of the router chiplet's `*FLITI` input. It captures 101-bit flits from the inter-chiplet link, checks packet framing, stores them in a DEPTH-entry FIFO and presents them to the router under a valid/ready handshake. Link flow control is credit-based: a credit is returned for every buffer slot freed.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLK` input 1: single clock; all state updates on rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `LFLITI` input 101: flit from link. Bit 100 = valid; bits 99:98 = type (01 head, 00 body, 10 tail, 11 head+tail); bits 97:0 = payload.
- `LCREDO` output 2: credits returned to the link this cycle, 0–2.
- `RFLITO` output 101: flit to router; bit 100 = valid (FIFO non-empty).
- `RREADY` input 1: router accepts `RFLITO` this cycle.
- `OCC` output $clog2(DEPTH)+1: current FIFO occupancy.
- `OVF` output 1: sticky; flit arrived while full.
- `ERRCNT` output 8: saturating count of framing errors.

## Operation
- Enqueue: `LFLITI[100]`=1, framing accepted, and not full (or full with dequeue in the same cycle) → write at tail pointer, tail pointer += 1 mod DEPTH.
- Dequeue: `RFLITO[100] && RREADY` → head pointer += 1 mod DEPTH.
- `RFLITO` is the FIFO head entry when non-empty. When empty it is all-zero, not stale data.
- Simultaneous enqueue and dequeue: `OCC` is unchanged. This is legal when full.
- Full with no dequeue and valid input: flit is dropped, `OVF` is set, and no credit is returned.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `OCC` is tracked separately so that full and empty are distinguishable.
- Framing FSM has two states, IDLE (expect head) and PKT (expect body/tail):
  - IDLE + head → PKT.
  - IDLE + head+tail → IDLE.
  - PKT + body → PKT.
  - PKT + tail → IDLE.
  - IDLE + body/tail → error; flit dropped; stay IDLE.
  - PKT + head or head+tail → error; flit dropped; stay PKT.
  - Error: `ERRCNT` += 1, saturating at 255. The dropped flit's credit is returned.
  - The FSM advances only on flits that are actually enqueued; an overflow drop does not advance it.
- Credits: `LCREDO` = registered (dequeue ? 1 : 0) + (framing drop ? 1 : 0).
- The upstream link starts with DEPTH credits after reset.
- Reset values: pointers 0, `OCC` 0, FSM IDLE, `RFLITO` 0, `LCREDO` 0, `OVF` 0, `ERRCNT` 0.
- Reset mid-operation flushes all buffered flits and returns no credits for them. The link partner is reset in the same cycle.

## Timing
- Flit enqueued at edge t is visible on `RFLITO` from cycle t+1. An empty buffer's latency is therefore 1 cycle.
- Combinational path `RREADY` → dequeue. No combinational path from `LFLITI` to `RFLITO`.
- `LCREDO` asserts in the cycle after the dequeue or drop that frees the slot.
- `OCC`, `OVF` and `ERRCNT` update at the same edge as the event that causes them.
- Throughput: 1 flit/cycle sustained when `RREADY` is held high.

## Configuration
- `FLIT_PKT_CHECK_EN` defined: framing FSM and `ERRCNT` are active as described above.
- Not defined:
  - Every valid flit is enqueued regardless of type.
  - The FSM is absent.
  - `ERRCNT` is tied to 0.
  - `LCREDO` never exceeds 1.

## Test plan
- Reset, then send head, body, tail on 3 consecutive cycles with `RREADY`=1 → `RFLITO` shows each flit one cycle later; `LCREDO`=1 on cycles t+2..t+4; `OCC` peaks at 1.
- `RREADY`=0, send 5 flits with DEPTH=4 → `OCC`=4; 5th flit dropped; `OVF`=1 and stays 1; raise `RREADY` → exactly 4 flits out in order, 4 credits returned.
- Full FIFO, `RREADY`=1 with a simultaneous valid body flit → `OCC` stays 4; new flit emerges after the 3 older ones.
- With `FLIT_PKT_CHECK_EN`, body flit while IDLE → dropped; `ERRCNT`=1; `LCREDO`=1 next cycle. Then head, head → second head dropped; `ERRCNT`=2.
- Dequeue and framing drop in the same cycle → `LCREDO`=2 next cycle. Also drive 300 framing errors → `ERRCNT` saturates at 255.
- Assert `RST` with 3 flits buffered → next cycle `OCC`=0, `RFLITO`=0, `OVF`=0, `LCREDO`=0, FSM IDLE; a subsequent body flit counts as an error.

Source files
------------

// File: rtl/flit_port_buffer.sv
// Credit-flow-controlled ingress FIFO for one router link port.
// Optional packet framing check enabled by defining FLIT_PKT_CHECK_EN.
module flit_port_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [100:0]             LFLITI,
  output logic [1:0]               LCREDO,
  output logic [100:0]             RFLITO,
  input  logic                     RREADY,
  output logic [$clog2(DEPTH):0]   OCC,
  output logic                     OVF,
  output logic [7:0]               ERRCNT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   OCC_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [100:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    lcredo_q, lcredo_d;
  logic          in_vld_s, deq_s, full_s, frame_ok_s, frame_err_s, enq_s, ovf_drop_s;

  assign in_vld_s = LFLITI[100];
  assign full_s   = (occ_q == OCC_FULL);
  // Dequeue is combinational on RREADY so a full buffer can accept in the same cycle.
  assign deq_s    = (occ_q != OCC_ZERO) && RREADY;

`ifdef FLIT_PKT_CHECK_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;
  localparam logic [1:0] T_BODY  = 2'b00;
  localparam logic [1:0] T_HEAD  = 2'b01;
  localparam logic [1:0] T_TAIL  = 2'b10;
  localparam logic [1:0] T_HT    = 2'b11;

  logic [0:0] state_q, state_d;
  logic [7:0] errcnt_q, errcnt_d;
  logic [1:0] typ_s;

  assign typ_s = LFLITI[99:98];

  always_comb begin
    frame_ok_s = 1'b0;
    state_d    = state_q;
    case (state_q)
      ST_IDLE: begin
        frame_ok_s = (typ_s == T_HEAD) || (typ_s == T_HT);
        if (enq_s && (typ_s == T_HEAD)) begin
          state_d = ST_PKT;
        end else begin
          state_d = state_q;
        end
      end
      ST_PKT: begin
        frame_ok_s = (typ_s == T_BODY) || (typ_s == T_TAIL);
        if (enq_s && (typ_s == T_TAIL)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        frame_ok_s = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    if (frame_err_s && (errcnt_q != 8'd255)) begin
      errcnt_d = errcnt_q + 8'd1;
    end else begin
      errcnt_d = errcnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign ERRCNT = errcnt_q;
`else
  assign frame_ok_s = 1'b1;
  assign ERRCNT     = 8'd0;
`endif

  // Framing rejects take priority; only well-framed flits can overflow.
  assign frame_err_s = in_vld_s && !frame_ok_s;
  assign enq_s       = in_vld_s && frame_ok_s && (!full_s || deq_s);
  assign ovf_drop_s  = in_vld_s && frame_ok_s && full_s && !deq_s;

  always_comb begin
    head_d   = deq_s ? head_q + PTR_ONE : head_q;
    tail_d   = enq_s ? tail_q + PTR_ONE : tail_q;
    ovf_d    = ovf_q | ovf_drop_s;
    lcredo_d = {1'b0, deq_s} + {1'b0, frame_err_s};
    case ({enq_s, deq_s})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= OCC_ZERO;
      ovf_q    <= 1'b0;
      lcredo_q <= 2'd0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      lcredo_q <= lcredo_d;
    end
  end

  // Storage needs no reset: the output is masked to zero whenever occupancy is zero.
  always_ff @(posedge CLK) begin
    if (enq_s) begin
      mem_q[tail_q] <= LFLITI;
    end
  end

  always_comb begin
    if (occ_q != OCC_ZERO) begin
      RFLITO = mem_q[head_q];
    end else begin
      RFLITO = 101'd0;
    end
  end

  assign LCREDO = lcredo_q;
  assign OCC    = occ_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_flit_port_buffer.sv
// Scoreboard bench for flit_port_buffer: directed stimulus pushes expected
// flits, a negedge monitor pops and compares whenever a flit is handed over.
module tb_flit_port_buffer;
  localparam int DEPTH = 4;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [100:0] LFLITI = 101'd0;
  logic [1:0]   LCREDO;
  logic [100:0] RFLITO;
  logic         RREADY = 1'b0;
  logic [2:0]   OCC;
  logic         OVF;
  logic [7:0]   ERRCNT;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  logic [100:0] exp_q[$];

  always #5 CLK = ~CLK;

  flit_port_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .LFLITI(LFLITI), .LCREDO(LCREDO), .RFLITO(RFLITO),
    .RREADY(RREADY), .OCC(OCC), .OVF(OVF), .ERRCNT(ERRCNT)
  );

  task automatic check(input string name, input logic [100:0] act, input logic [100:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [100:0] mk(input logic [1:0] t, input int id);
    return {1'b1, t, 98'(id)};
  endfunction

  // Monitor: every handed-over flit must match the head of the expected queue.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (RFLITO[100] === 1'b1 && RREADY === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit", RFLITO, 101'd0);
        end else begin
          check("flit_order", RFLITO, exp_q.pop_front());
          n_pop++;
        end
      end else if (RFLITO[100] !== 1'b1) begin
        check("empty_is_zero", RFLITO, 101'd0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input int id,
                       input logic rdy, input logic acc);
    LFLITI = v ? mk(t, id) : 101'd0;
    RREADY = rdy;
    if (v && acc) exp_q.push_back(mk(t, id));
    tick();
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    LFLITI = 101'd0;
    RREADY = 1'b0;
    tick();
    RST = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int cr;
    int pops0;

    // Reset state
    do_reset();
    check("rst_occ", OCC, 0);
    check("rst_rflito", RFLITO, 0);
    check("rst_ovf", OVF, 0);
    check("rst_lcredo", LCREDO, 0);
    check("rst_errcnt", ERRCNT, 0);

    // head, body, tail streamed with RREADY high
    drive(1'b1, T_HEAD, 1, 1'b1, 1'b1);
    check("t1_occ_a", OCC, 1);
    check("t1_cred_a", LCREDO, 0);
    check("t1_out_head", RFLITO, mk(T_HEAD, 1));
    drive(1'b1, T_BODY, 2, 1'b1, 1'b1);
    check("t1_occ_b", OCC, 1);
    check("t1_cred_b", LCREDO, 1);
    check("t1_out_body", RFLITO, mk(T_BODY, 2));
    drive(1'b1, T_TAIL, 3, 1'b1, 1'b1);
    check("t1_occ_c", OCC, 1);
    check("t1_cred_c", LCREDO, 1);
    drive(1'b0, T_BODY, 0, 1'b1, 1'b0);
    check("t1_occ_d", OCC, 0);
    check("t1_cred_d", LCREDO, 1);
    drive(1'b0, T_BODY, 0, 1'b1, 1'b0);
    check("t1_cred_e", LCREDO, 0);

    // Overflow: 5 flits into a 4-deep buffer with RREADY low
    drive(1'b1, T_HEAD, 10, 1'b0, 1'b1);
    drive(1'b1, T_BODY, 11, 1'b0, 1'b1);
    drive(1'b1, T_BODY, 12, 1'b0, 1'b1);
    drive(1'b1, T_BODY, 13, 1'b0, 1'b1);
    check("t2_occ_full", OCC, 4);
    check("t2_ovf_pre", OVF, 0);
    drive(1'b1, T_BODY, 14, 1'b0, 1'b0);
    check("t2_occ_after_drop", OCC, 4);
    check("t2_ovf_set", OVF, 1);
    check("t2_no_credit", LCREDO, 0);
    cr    = 0;
    pops0 = n_pop;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, T_BODY, 0, 1'b1, 1'b0);
      cr += int'(LCREDO);
    end
    check("t2_credits", cr, 4);
    check("t2_pops", n_pop - pops0, 4);
    check("t2_occ_drained", OCC, 0);
    check("t2_ovf_sticky", OVF, 1);
    drive(1'b1, T_TAIL, 15, 1'b1, 1'b1);
    drive(1'b0, T_BODY, 0, 1'b1, 1'b0);

    // Reset with 3 flits buffered
    drive(1'b1, T_HEAD, 20, 1'b0, 1'b1);
    drive(1'b1, T_BODY, 21, 1'b0, 1'b1);
    drive(1'b1, T_BODY, 22, 1'b0, 1'b1);
    check("t5_occ_3", OCC, 3);
    do_reset();
    check("t5_occ", OCC, 0);
    check("t5_rflito", RFLITO, 0);
    check("t5_ovf", OVF, 0);
    check("t5_lcredo", LCREDO, 0);
`ifdef FLIT_PKT_CHECK_EN
    drive(1'b1, T_BODY, 23, 1'b1, 1'b0);
    check("t5_body_err", ERRCNT, 1);
    check("t5_body_occ", OCC, 0);
    check("t5_body_cred", LCREDO, 1);
`else
    drive(1'b1, T_BODY, 23, 1'b1, 1'b1);
    check("t5_body_occ", OCC, 1);
    check("t5_body_err", ERRCNT, 0);
`endif
    drive(1'b0, T_BODY, 0, 1'b1, 1'b0);

    // Full buffer with simultaneous dequeue and enqueue
    do_reset();
    drive(1'b1, T_HEAD, 30, 1'b0, 1'b1);
    drive(1'b1, T_BODY, 31, 1'b0, 1'b1);
    drive(1'b1, T_BODY, 32, 1'b0, 1'b1);
    drive(1'b1, T_BODY, 33, 1'b0, 1'b1);
    check("t3_occ_full", OCC, 4);
    drive(1'b1, T_BODY, 34, 1'b1, 1'b1);
    check("t3_occ_hold", OCC, 4);
    check("t3_ovf", OVF, 0);
    check("t3_cred", LCREDO, 1);
    for (int i = 0; i < 5; i++) drive(1'b0, T_BODY, 0, 1'b1, 1'b0);
    check("t3_occ_drained", OCC, 0);
    check("t3_q_empty", exp_q.size(), 0);

`ifdef FLIT_PKT_CHECK_EN
    // Framing errors, dequeue + drop in one cycle, saturation
    do_reset();
    drive(1'b1, T_BODY, 40, 1'b1, 1'b0);
    check("t4_err1", ERRCNT, 1);
    check("t4_occ1", OCC, 0);
    check("t4_cred1", LCREDO, 1);
    drive(1'b1, T_HEAD, 41, 1'b1, 1'b1);
    check("t4_occ2", OCC, 1);
    check("t4_cred2", LCREDO, 0);
    drive(1'b1, T_HEAD, 42, 1'b1, 1'b0);
    check("t4_err2", ERRCNT, 2);
    check("t4_cred_dual", LCREDO, 2);
    check("t4_occ3", OCC, 0);
    drive(1'b1, T_HT, 43, 1'b0, 1'b0);
    check("t4_ht_in_pkt", ERRCNT, 3);
    for (int i = 0; i < 300; i++) drive(1'b1, T_HEAD, 100 + i, 1'b0, 1'b0);
    check("t4_sat", ERRCNT, 255);
    check("t4_sat_cred", LCREDO, 1);
    check("t4_sat_occ", OCC, 0);
    drive(1'b1, T_TAIL, 50, 1'b1, 1'b1);
    check("t4_tail_ok", OCC, 1);
    drive(1'b0, T_BODY, 0, 1'b1, 1'b0);
`else
    // Without framing check every type is buffered and credits never exceed 1
    do_reset();
    drive(1'b1, T_BODY, 40, 1'b1, 1'b1);
    check("t4_occ1", OCC, 1);
    check("t4_err", ERRCNT, 0);
    drive(1'b1, T_HT, 41, 1'b1, 1'b1);
    check("t4_occ2", OCC, 1);
    check("t4_cred", LCREDO, 1);
    drive(1'b0, T_BODY, 0, 1'b1, 1'b0);
    check("t4_occ3", OCC, 0);
`endif
    drive(1'b0, T_BODY, 0, 1'b1, 1'b0);
    drive(1'b0, T_BODY, 0, 1'b1, 1'b0);
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
